// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared constants for the instruction-decode stage of the 5-stage RISC-V
// pipeline: default datapath/register-file geometry, the control-bundle width,
// the NOP control value used for bubbles and the hard-wired zero register.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = $clog2(DEF_NREGS);
    localparam int DEF_CTRL_W = 12;
    localparam int DEF_CNT_W  = 16;

    // A bubble carries an all-zero control bundle: no write-back, no memory op.
    localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

    // Register x0 is hard-wired to zero.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_regfile.sv
// -----------------------------------------------------------------------------
// pipeline_regfile
// NREGS x XLEN architectural register file: one write port, two combinational
// read ports, asynchronous clear. Register 0 always reads as zero and is never
// written.
//
// Optional build macro PIPELINE_ID_WB_BYPASS_EN: when defined, a read whose
// address matches the active write port returns the write data in the same
// cycle (write-through). When undefined, reads return the stored value.
//
// Ports:
//   clk, rst        clock, asynchronous active-high clear
//   we, waddr, wdata write port (ignored when waddr == 0)
//   raddr1, rdata1  read port 1
//   raddr2, rdata2  read port 2
// -----------------------------------------------------------------------------
module pipeline_regfile
    import pipeline_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    assign wr_en = we && (waddr != AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == AW'(REG_ZERO)) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == AW'(REG_ZERO)) ? '0 : regs_q[raddr2];
`ifdef PIPELINE_ID_WB_BYPASS_EN
        // Write-through: the value being written back this cycle wins.
        if (wr_en && (waddr == raddr1)) rdata1 = wdata;
        if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/pipeline_id_hazard.sv
// -----------------------------------------------------------------------------
// pipeline_id_hazard
// Instruction-decode stage: register file, load-use hazard detection and the
// ID/EX pipeline register with flush > hold > load-use > advance priority.
// A load-use hazard inserts exactly one bubble while stall_out freezes PC and
// IF/ID; every such bubble is counted in the saturating stall_cnt.
//
// Optional build macro PIPELINE_ID_WB_BYPASS_EN: when undefined the register
// file has no write-through path, so an ID read of the register being written
// back this cycle is treated as a hazard too (one extra, counted bubble).
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   valid_in, inst_in, pc_in    instruction from IF/ID
//   ctrl_in, mem_read_in        decoded control bundle, load flag
//   use_rs1_in, use_rs2_in      source-operand usage flags
//   imm_in                      generated immediate
//   wb_we, wb_addr, wb_data     write-back port
//   flush_in                    taken branch/jump in EX: kill ID
//   hold_in                     global freeze
//   stall_out                   hold PC and IF/ID this cycle
//   ex_*                        ID/EX register contents
//   stall_cnt                   cumulative load-use stall cycles
// -----------------------------------------------------------------------------
module pipeline_id_hazard
    import pipeline_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       inst_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              mem_read_in,
    input  logic              use_rs1_in,
    input  logic              use_rs2_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush_in,
    input  logic              hold_in,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [AW-1:0]     ex_rs1_addr,
    output logic [AW-1:0]     ex_rs2_addr,
    output logic [AW-1:0]     ex_rd,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [AW-1:0]     rs1, rs2, rd;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic              lu_ex, lu_wb, lu;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [AW-1:0]     rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mem_read_q, mem_read_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign rs1 = AW'(inst_in[19:15]);
    assign rs2 = AW'(inst_in[24:20]);
    assign rd  = AW'(inst_in[11:7]);

    pipeline_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data)
    );

    // Load in EX whose destination is a source of the instruction in ID.
    assign lu_ex = valid_in && valid_q && mem_read_q && (rd_q != AW'(REG_ZERO)) &&
                   ((use_rs1_in && (rs1 == rd_q)) || (use_rs2_in && (rs2 == rd_q)));

`ifdef PIPELINE_ID_WB_BYPASS_EN
    assign lu_wb = 1'b0;
`else
    // Without write-through the register file would return the stale value,
    // so wait one cycle for the write to land.
    assign lu_wb = valid_in && wb_we && (wb_addr != AW'(REG_ZERO)) &&
                   ((use_rs1_in && (rs1 == wb_addr)) || (use_rs2_in && (rs2 == wb_addr)));
`endif

    assign lu        = lu_ex || lu_wb;
    assign stall_out = !flush_in && (lu || hold_in);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        mem_read_d = mem_read_q;
        if (flush_in || (lu && !hold_in)) begin
            // Bubble: every field cleared, control forced to NOP.
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_d       = '0;
            imm_d      = '0;
            ctrl_d     = CTRL_W'(CTRL_NOP);
            mem_read_d = 1'b0;
        end else if (!hold_in) begin
            valid_d    = valid_in;
            pc_d       = pc_in;
            rs1_data_d = rs1_data;
            rs2_data_d = rs2_data;
            rs1_addr_d = rs1;
            rs2_addr_d = rs2;
            rd_d       = rd;
            imm_d      = imm_in;
            ctrl_d     = valid_in ? ctrl_in : CTRL_W'(CTRL_NOP);
            mem_read_d = valid_in && mem_read_in;
        end
    end

    // Only bubbles actually inserted by a load-use hazard are counted.
    always_comb begin
        cnt_d = cnt_q;
        if (lu && !flush_in && !hold_in && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            ctrl_q     <= '0;
            mem_read_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            mem_read_q <= mem_read_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_rs1_addr = rs1_addr_q;
    assign ex_rs2_addr = rs2_addr_q;
    assign ex_rd       = rd_q;
    assign ex_imm      = imm_q;
    assign ex_ctrl     = ctrl_q;
    assign ex_mem_read = mem_read_q;
    assign stall_cnt   = cnt_q;

endmodule
